incoming_response_buffer: RTL and testbench

Receive-side counterpart of the outgoing response buffer. It sits between the downstream AXI slave's R channel and the ROB. It accepts R beats and attaches to each the ROB tag recorded when the read was issued. It checks burst length against the issued length, then buffers the beats and presents them to the ROB. A per-ID tag table is written by the AR issue logic through a small allocation port.

---
 rtl/rob_pkg.sv | 28 ++
 rtl/r_if.sv | 18 +
 rtl/fifo.sv | 41 ++++
 rtl/incoming_response_buffer.sv | 125 ++++++++++++
 tb/tb_incoming_response_buffer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared types for the ROB response path: R-beat payload, tag-table entry and AXI resp codes.
package rob_pkg;

   localparam int ID_W   = 4;
   localparam int DATA_W = 64;
   localparam int RESP_W = 2;
   localparam int TAG_W  = 4;
   localparam int LEN_W  = 8;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [RESP_W-1:0] resp;
      logic              last;
      logic [TAG_W-1:0]  tagid;
   } r_resp_t;

   typedef struct packed {
      logic             valid;
      logic [LEN_W-1:0] len;
      logic [TAG_W-1:0] tagid;
      logic [LEN_W-1:0] beat_cnt;
   } tag_entry_t;

endpackage

// File: rtl/r_if.sv
// AXI R-channel style handshake bus, extended with the ROB tag that travels with each beat.
interface r_if #(
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 64,
   parameter int RESP_WIDTH = 2,
   parameter int TAG_WIDTH  = 4
);
   logic                  valid;
   logic                  ready;
   logic [ID_WIDTH-1:0]   id;
   logic [DATA_WIDTH-1:0] data;
   logic [RESP_WIDTH-1:0] resp;
   logic                  last;
   logic [TAG_WIDTH-1:0]  tagid;

   modport master (output valid, id, data, resp, last, tagid, input ready);
   modport slave  (input valid, id, data, resp, last, tagid, output ready);
endinterface

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO; dout always presents the oldest entry while !empty.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   // Extra pointer MSB distinguishes full from empty when the addresses match.
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign dout  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (wr_en && !full)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (rd_en && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (wr_en && !full) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/incoming_response_buffer.sv
// Tags incoming R beats with the ROB tag recorded at AR issue, checks burst length,
// and buffers the beats through a FIFO plus a registered output stage towards the ROB.
module incoming_response_buffer
   import rob_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 64,
   parameter int RESP_WIDTH = 2,
   parameter int TAG_WIDTH  = 4,
   parameter int LEN_WIDTH  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_valid,
   output logic                 alloc_ready,
   input  logic [ID_WIDTH-1:0]  alloc_id,
   input  logic [LEN_WIDTH-1:0] alloc_len,
   input  logic [TAG_WIDTH-1:0] alloc_tagid,
   r_if.slave                   in_if,
   r_if.master                  out_if,
   input  logic                 err_clr,
   output logic                 err_unexp,
   output logic                 err_len,
   output logic [ID_WIDTH:0]    alloc_count
);
   localparam int N_IDS     = 2**ID_WIDTH;
   localparam int PAYLOAD_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1 + TAG_WIDTH;

   tag_entry_t          r_table [N_IDS];
   logic [ID_WIDTH:0]   r_alloc_count;
   logic                r_err_unexp;
   logic                r_err_len;
   logic                r_out_valid;
   r_resp_t             r_out;

   tag_entry_t          w_ent;
   r_resp_t             w_push;
   logic                w_in_fire, w_hit, w_unexp, w_at_len, w_free, w_len_err, w_alloc;
   logic                w_fifo_empty, w_fifo_full, w_pop;
   logic [PAYLOAD_W-1:0] w_fifo_dout;

   assign alloc_ready = !r_table[alloc_id].valid;
   assign w_alloc     = alloc_valid && alloc_ready;

   assign in_if.ready = !w_fifo_full;
   assign w_in_fire   = in_if.valid && in_if.ready;
   assign w_ent       = r_table[in_if.id];
   assign w_hit       = w_in_fire && w_ent.valid;
   assign w_unexp     = w_in_fire && !w_ent.valid;
   assign w_at_len    = (w_ent.beat_cnt == w_ent.len);
   assign w_free      = w_hit && (in_if.last || w_at_len);
   assign w_len_err   = w_hit && (in_if.last != w_at_len);

   // NOTE: every field gets a value on every pass, so no latch can be inferred.
   always_comb begin
      w_push       = '0;
      w_push.id    = in_if.id;
      w_push.data  = in_if.data;
      w_push.resp  = w_len_err ? RESP_SLVERR : in_if.resp;
      w_push.last  = in_if.last || w_at_len;
      w_push.tagid = w_ent.tagid;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_IDS; i++) r_table[i] <= '0;
         r_alloc_count <= '0;
      end else begin
         if (w_free)     r_table[in_if.id].valid    <= 1'b0;
         else if (w_hit) r_table[in_if.id].beat_cnt <= w_ent.beat_cnt + 1'b1;
         // A free and an alloc never target the same entry: alloc needs it already invalid.
         if (w_alloc)
            r_table[alloc_id] <= '{valid: 1'b1, len: alloc_len, tagid: alloc_tagid, beat_cnt: '0};
         if (w_alloc && !w_free)      r_alloc_count <= r_alloc_count + 1'b1;
         else if (!w_alloc && w_free) r_alloc_count <= r_alloc_count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_unexp <= 1'b0;
         r_err_len   <= 1'b0;
      end else begin
         r_err_unexp <= w_unexp   ? 1'b1 : (err_clr ? 1'b0 : r_err_unexp);
         r_err_len   <= w_len_err ? 1'b1 : (err_clr ? 1'b0 : r_err_len);
      end
   end

   fifo #(.WIDTH(PAYLOAD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .wr_en (w_hit),
      .rd_en (w_pop),
      .din   (w_push),
      .dout  (w_fifo_dout),
      .empty (w_fifo_empty),
      .full  (w_fifo_full)
   );

   assign w_pop = !w_fifo_empty && (!r_out_valid || out_if.ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                r_out_valid <= 1'b0;
      else if (w_pop)          r_out_valid <= 1'b1;
      else if (out_if.ready)   r_out_valid <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_pop) r_out <= r_resp_t'(w_fifo_dout);
   end

   assign out_if.valid = r_out_valid;
   assign out_if.id    = r_out.id;
   assign out_if.data  = r_out.data;
   assign out_if.resp  = r_out.resp;
   assign out_if.last  = r_out.last;
   assign out_if.tagid = r_out.tagid;

   assign err_unexp   = r_err_unexp;
   assign err_len     = r_err_len;
   assign alloc_count = r_alloc_count;

endmodule

// File: tb/tb_incoming_response_buffer.sv
// Self-checking bench: directed sequences, a vector table of single-beat bursts,
// and a randomized run scored against a queue-based reference model.
module tb_incoming_response_buffer;
   import rob_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_valid;
   logic       alloc_ready;
   logic [3:0] alloc_id;
   logic [7:0] alloc_len;
   logic [3:0] alloc_tagid;
   logic       err_clr;
   logic       err_unexp;
   logic       err_len;
   logic [4:0] alloc_count;

   r_if in_if ();
   r_if out_if ();

   incoming_response_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .alloc_valid (alloc_valid),
      .alloc_ready (alloc_ready),
      .alloc_id    (alloc_id),
      .alloc_len   (alloc_len),
      .alloc_tagid (alloc_tagid),
      .in_if       (in_if),
      .out_if      (out_if),
      .err_clr     (err_clr),
      .err_unexp   (err_unexp),
      .err_len     (err_len),
      .alloc_count (alloc_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0] id;
      logic [7:0] len;
      logic [3:0] tag;
      logic       last;
      logic [1:0] resp_in;
      logic [1:0] exp_resp;
      logic       exp_last;
      logic       exp_err;
      logic       exp_free;
   } vec_t;

   vec_t vecs [6];

   // Reference model state: per-ID burst bookkeeping and the ordered list of beats owed to the ROB.
   bit         m_v   [16];
   int         m_len [16];
   int         m_cnt [16];
   logic [3:0] m_tag [16];
   r_resp_t    m_q   [$];
   bit         m_eu, m_el;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid  = 1'b0;
      in_if.valid  = 1'b0;
      in_if.last   = 1'b0;
      in_if.id     = '0;
      in_if.data   = '0;
      in_if.resp   = '0;
      in_if.tagid  = '0;
      err_clr      = 1'b0;
   endtask

   task automatic do_alloc(input logic [3:0] id, input logic [7:0] len, input logic [3:0] tag);
      alloc_valid = 1'b1;
      alloc_id    = id;
      alloc_len   = len;
      alloc_tagid = tag;
      #1;
      check("alloc_ready_before_alloc", alloc_ready, 1);
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [3:0] id, input logic [63:0] data,
                            input logic [1:0] resp, input logic last);
      in_if.valid = 1'b1;
      in_if.id    = id;
      in_if.data  = data;
      in_if.resp  = resp;
      in_if.last  = last;
      for (int w = 0; w < 50 && !in_if.ready; w++) tick();
      if (!in_if.ready) check("beat_accept_timeout", 0, 1);
      tick();
      in_if.valid = 1'b0;
      in_if.last  = 1'b0;
   endtask

   task automatic wait_out();
      for (int w = 0; w < 20 && !out_if.valid; w++) tick();
      if (!out_if.valid) check("out_valid_timeout", 0, 1);
   endtask

   task automatic clear_errs();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
      m_q.delete();
      m_eu = 1'b0;
      m_el = 1'b0;
   endtask

   // Evaluated between edges with inputs settled: checks combinational outputs and
   // the beat being handed to the ROB, then advances the model across the coming edge.
   task automatic model_cycle();
      r_resp_t e;
      bit      a_ok, at_len, set_u, set_l;
      int      id;
      check("rand_alloc_ready", alloc_ready, !m_v[alloc_id]);
      a_ok = alloc_valid && !m_v[alloc_id];
      if (out_if.valid && out_if.ready) begin
         if (m_q.size() == 0) check("rand_unexpected_out", 1, 0);
         else begin
            e = m_q.pop_front();
            check("rand_out_beat", {out_if.id, out_if.data, out_if.resp, out_if.last, out_if.tagid}, e);
         end
      end
      set_u = 1'b0;
      set_l = 1'b0;
      if (in_if.valid && in_if.ready) begin
         id = int'(in_if.id);
         if (!m_v[id]) set_u = 1'b1;
         else begin
            at_len  = (m_cnt[id] == m_len[id]);
            e.id    = in_if.id;
            e.data  = in_if.data;
            e.resp  = (in_if.last != at_len) ? RESP_SLVERR : in_if.resp;
            e.last  = in_if.last || at_len;
            e.tagid = m_tag[id];
            m_q.push_back(e);
            set_l = (in_if.last != at_len);
            if (in_if.last || at_len) m_v[id] = 1'b0;
            else m_cnt[id] = m_cnt[id] + 1;
         end
      end
      if (a_ok) begin
         m_v[alloc_id]   = 1'b1;
         m_len[alloc_id] = int'(alloc_len);
         m_tag[alloc_id] = alloc_tagid;
         m_cnt[alloc_id] = 0;
      end
      m_eu = set_u ? 1'b1 : (err_clr ? 1'b0 : m_eu);
      m_el = set_l ? 1'b1 : (err_clr ? 1'b0 : m_el);
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m_v[i]);
      return n;
   endfunction

   initial begin
      int  sent, rcv;
      bit  acc;

      //                id     len    tag    last  rin    eresp  elast eerr  efree
      vecs[0] = '{4'd2, 8'd1, 4'h5, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1};
      vecs[1] = '{4'd1, 8'd0, 4'h7, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1};
      vecs[2] = '{4'd6, 8'd0, 4'h3, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{4'd7, 8'd2, 4'h9, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{4'd8, 8'd0, 4'hC, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{4'd9, 8'd5, 4'h1, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1};

      rst = 1'b0;
      idle();
      alloc_id     = '0;
      alloc_len    = '0;
      alloc_tagid  = '0;
      out_if.ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", out_if.valid, 0);
      check("reset_err_unexp", err_unexp, 0);
      check("reset_err_len", err_len, 0);
      check("reset_alloc_count", alloc_count, 0);
      check("reset_in_ready", in_if.ready, 1);
      rst = 1'b1;
      tick();

      // Four-beat burst streams out back to back with the recorded tag.
      do_alloc(4'd3, 8'd3, 4'hA);
      check("burst_count_after_alloc", alloc_count, 1);
      for (int i = 0; i < 6; i++) begin
         in_if.valid = (i < 4);
         in_if.id    = 4'd3;
         in_if.data  = 64'h1000 + 64'(i);
         in_if.resp  = RESP_OKAY;
         in_if.last  = (i == 3);
         #1;
         if (i >= 2) begin
            check("burst_out_valid", out_if.valid, 1);
            check("burst_out_data", out_if.data, 64'h1000 + 64'(i - 2));
            check("burst_out_tag", out_if.tagid, 4'hA);
            check("burst_out_resp", out_if.resp, 2'b00);
            check("burst_out_last", out_if.last, (i == 5));
         end
         tick();
         if (i == 2) check("burst_count_mid", alloc_count, 1);
         if (i == 3) check("burst_count_end", alloc_count, 0);
      end
      idle();
      check("burst_out_idle", out_if.valid, 0);

      // Beat for an ID that was never allocated.
      in_if.valid = 1'b1;
      in_if.id    = 4'd5;
      in_if.last  = 1'b1;
      #1;
      check("unexp_in_ready", in_if.ready, 1);
      tick();
      idle();
      check("unexp_flag", err_unexp, 1);
      for (int i = 0; i < 3; i++) begin
         check("unexp_dropped", out_if.valid, 0);
         tick();
      end
      clear_errs();
      check("unexp_cleared", err_unexp, 0);
      in_if.valid = 1'b1;
      in_if.id    = 4'd5;
      err_clr     = 1'b1;
      tick();
      idle();
      check("unexp_set_beats_clear", err_unexp, 1);
      clear_errs();
      check("unexp_cleared_again", err_unexp, 0);

      // Single-beat bursts covering normal, early-last and missing-last endings.
      for (int v = 0; v < 6; v++) begin
         do_alloc(vecs[v].id, vecs[v].len, vecs[v].tag);
         send_beat(vecs[v].id, 64'hC0DE_0000 + 64'(v), vecs[v].resp_in, vecs[v].last);
         wait_out();
         check("vec_id", out_if.id, vecs[v].id);
         check("vec_data", out_if.data, 64'hC0DE_0000 + 64'(v));
         check("vec_resp", out_if.resp, vecs[v].exp_resp);
         check("vec_last", out_if.last, vecs[v].exp_last);
         check("vec_tag", out_if.tagid, vecs[v].tag);
         tick();
         check("vec_err_len", err_len, vecs[v].exp_err);
         alloc_id = vecs[v].id;
         #1;
         check("vec_entry_free", alloc_ready, vecs[v].exp_free);
         clear_errs();
         check("vec_err_len_cleared", err_len, 0);
      end

      // id 1 ended on a forced last; a further beat for it is unexpected.
      send_beat(4'd1, 64'hDEAD, 2'b00, 1'b0);
      check("late_beat_unexp", err_unexp, 1);
      tick();
      check("late_beat_dropped", out_if.valid, 0);
      clear_errs();

      // Allocation and beat for the same free ID in one cycle: beat is unexpected, alloc wins.
      alloc_valid = 1'b1;
      alloc_id    = 4'd10;
      alloc_len   = 8'd0;
      alloc_tagid = 4'h4;
      in_if.valid = 1'b1;
      in_if.id    = 4'd10;
      in_if.last  = 1'b1;
      tick();
      idle();
      #1;
      check("same_cycle_unexp", err_unexp, 1);
      check("same_cycle_allocated", alloc_ready, 0);
      check("same_cycle_count", alloc_count, 2);
      clear_errs();

      // Backpressure: FIFO_DEPTH entries plus the output stage fill, then drain in order.
      out_if.ready = 1'b0;
      do_alloc(4'd0, 8'd19, 4'h5);
      sent = 0;
      for (int c = 0; c < 25; c++) begin
         in_if.valid = (sent < 20);
         in_if.id    = 4'd0;
         in_if.data  = 64'hB000 + 64'(sent);
         in_if.resp  = RESP_OKAY;
         in_if.last  = (sent == 19);
         #1;
         acc = in_if.valid && in_if.ready;
         tick();
         if (acc) sent++;
      end
      in_if.valid = 1'b0;
      #1;
      check("bp_accepted", sent, 17);
      check("bp_in_ready_low", in_if.ready, 0);
      check("bp_out_held_valid", out_if.valid, 1);
      check("bp_out_held_data", out_if.data, 64'hB000);
      out_if.ready = 1'b1;
      rcv = 0;
      for (int c = 0; c < 100 && rcv < 20; c++) begin
         in_if.valid = (sent < 20);
         in_if.data  = 64'hB000 + 64'(sent);
         in_if.last  = (sent == 19);
         #1;
         acc = in_if.valid && in_if.ready;
         if (out_if.valid) begin
            check("bp_drain_data", out_if.data, 64'hB000 + 64'(rcv));
            check("bp_drain_last", out_if.last, (rcv == 19));
            rcv++;
         end
         tick();
         if (acc) sent++;
      end
      idle();
      check("bp_received", rcv, 20);
      check("bp_err_len", err_len, 0);
      alloc_id = 4'd0;
      #1;
      check("bp_entry_freed", alloc_ready, 1);

      // Asynchronous reset in the middle of a burst.
      out_if.ready = 1'b0;
      do_alloc(4'd4, 8'd3, 4'h2);
      send_beat(4'd4, 64'h44, 2'b00, 1'b0);
      send_beat(4'd4, 64'h45, 2'b00, 1'b0);
      send_beat(4'd9, 64'h99, 2'b00, 1'b1);
      tick();
      check("pre_reset_valid", out_if.valid, 1);
      check("pre_reset_unexp", err_unexp, 1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_reset_out_valid", out_if.valid, 0);
      check("mid_reset_err_unexp", err_unexp, 0);
      check("mid_reset_err_len", err_len, 0);
      check("mid_reset_alloc_count", alloc_count, 0);
      tick();
      rst = 1'b1;
      tick();
      out_if.ready = 1'b1;
      send_beat(4'd4, 64'h46, 2'b00, 1'b1);
      check("post_reset_old_id_unexp", err_unexp, 1);
      tick();
      check("post_reset_no_out", out_if.valid, 0);

      // Randomized traffic on a few IDs against the reference model.
      rst = 1'b0;
      idle();
      tick();
      rst = 1'b1;
      tick();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         alloc_valid  = ($urandom_range(0, 2) == 0);
         alloc_id     = 4'($urandom_range(0, 3));
         alloc_len    = 8'($urandom_range(0, 3));
         alloc_tagid  = 4'($urandom);
         in_if.valid  = 1'($urandom_range(0, 1));
         in_if.id     = 4'($urandom_range(0, 3));
         in_if.data   = {$urandom, $urandom};
         in_if.resp   = 2'($urandom);
         in_if.last   = ($urandom_range(0, 3) == 0);
         out_if.ready = ($urandom_range(0, 3) != 0);
         err_clr      = ($urandom_range(0, 15) == 0);
         #1;
         model_cycle();
         tick();
         check("rand_err_unexp", err_unexp, m_eu);
         check("rand_err_len", err_len, m_el);
         check("rand_alloc_count", alloc_count, model_count());
      end
      idle();
      out_if.ready = 1'b1;
      for (int c = 0; c < 100 && (m_q.size() != 0 || out_if.valid); c++) begin
         #1;
         model_cycle();
         tick();
      end
      check("rand_drain_remaining", m_q.size(), 0);
      check("rand_drain_out_idle", out_if.valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
